// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: opcodes, FSM states and ALU operations.
// The ALU decoder imports the same aluop constants.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StMemAdr  = 4'd2,
    StMemRd   = 4'd3,
    StMemWb   = 4'd4,
    StMemWr   = 4'd5,
    StRtypeEx = 4'd6,
    StRtypeWb = 4'd7,
    StBeqEx   = 4'd8,
    StAddiEx  = 4'd9,
    StAddiWb  = 4'd10,
    StOriEx   = 4'd11,
    StOriWb   = 4'd12,
    StJEx     = 4'd13
  } state_e;

  function automatic logic is_legal(logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_J) || (op == OP_BEQ) || (op == OP_ADDI) ||
           (op == OP_ORI) || (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// Control bundle between the main FSM (master) and the multi-cycle datapath (slave).
interface mc_ctrl_fsm_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       memwrite;
  logic       irwrite;
  logic       regwrite;
  logic       pcwrite;
  logic       branch;
  logic       iord;
  logic       alusrca;
  logic       regdst;
  logic       memtoreg;
  logic       immzext;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic [1:0] aluop;
  logic       illegal;
  logic [3:0] state;

  modport master (
    input  opcode, mem_ready,
    output memwrite, irwrite, regwrite, pcwrite, branch,
    output iord, alusrca, regdst, memtoreg, immzext,
    output alusrcb, pcsrc, aluop, illegal, state
  );

  modport slave (
    output opcode, mem_ready,
    input  memwrite, irwrite, regwrite, pcwrite, branch,
    input  iord, alusrca, regdst, memtoreg, immzext,
    input  alusrcb, pcsrc, aluop, illegal, state
  );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// Main control FSM for the multi-cycle MIPS datapath: one state per cycle,
// stalling in FETCH, MEMRD and MEMWR until mem_ready.
module mc_ctrl_fsm
  import mips_ctrl_pkg::*;
(
  input logic           clk,
  input logic           reset_n,
  mc_ctrl_fsm_if.master bus
);

  state_e state_q, state_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StFetch:  if (bus.mem_ready) state_d = StDecode;
      StDecode: begin
        case (bus.opcode)
          OP_LW, OP_SW: state_d = StMemAdr;
          OP_RTYPE:     state_d = StRtypeEx;
          OP_BEQ:       state_d = StBeqEx;
          OP_ADDI:      state_d = StAddiEx;
          OP_ORI:       state_d = StOriEx;
          OP_J:         state_d = StJEx;
          default:      state_d = StFetch;
        endcase
      end
      StMemAdr:  state_d = (bus.opcode == OP_LW) ? StMemRd : StMemWr;
      StMemRd:   if (bus.mem_ready) state_d = StMemWb;
      StMemWr:   if (bus.mem_ready) state_d = StFetch;
      StRtypeEx: state_d = StRtypeWb;
      StAddiEx:  state_d = StAddiWb;
      StOriEx:   state_d = StOriWb;
      StMemWb, StRtypeWb, StAddiWb, StOriWb, StBeqEx, StJEx: state_d = StFetch;
      default:   state_d = StFetch;
    endcase
  end

  always_comb begin
    bus.memwrite = 1'b0;
    bus.irwrite  = 1'b0;
    bus.regwrite = 1'b0;
    bus.pcwrite  = 1'b0;
    bus.branch   = 1'b0;
    bus.iord     = 1'b0;
    bus.alusrca  = 1'b0;
    bus.regdst   = 1'b0;
    bus.memtoreg = 1'b0;
    bus.immzext  = 1'b0;
    bus.alusrcb  = 2'b00;
    bus.pcsrc    = 2'b00;
    bus.aluop    = ALUOP_ADD;
    bus.illegal  = 1'b0;
    case (state_q)
      StFetch: begin
        // Fetch enables follow the handshake so a stalled fetch never latches IR/PC.
        bus.alusrcb = 2'b01;
        bus.irwrite = bus.mem_ready;
        bus.pcwrite = bus.mem_ready;
      end
      StDecode: begin
        bus.alusrcb = 2'b11;
        bus.illegal = !is_legal(bus.opcode);
      end
      StMemAdr: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = 2'b10;
      end
      StMemRd: bus.iord = 1'b1;
      StMemWb: begin
        bus.memtoreg = 1'b1;
        bus.regwrite = 1'b1;
      end
      StMemWr: begin
        bus.iord     = 1'b1;
        bus.memwrite = 1'b1;
      end
      StRtypeEx: begin
        bus.alusrca = 1'b1;
        bus.aluop   = ALUOP_FUNCT;
      end
      StRtypeWb: begin
        bus.regdst   = 1'b1;
        bus.regwrite = 1'b1;
      end
      StBeqEx: begin
        bus.alusrca = 1'b1;
        bus.aluop   = ALUOP_SUB;
        bus.pcsrc   = 2'b01;
        bus.branch  = 1'b1;
      end
      StAddiEx: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = 2'b10;
      end
      StOriEx: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = 2'b10;
        bus.aluop   = ALUOP_OR;
        bus.immzext = 1'b1;
      end
      StAddiWb, StOriWb: bus.regwrite = 1'b1;
      StJEx: begin
        bus.pcsrc   = 2'b10;
        bus.pcwrite = 1'b1;
      end
      default: ;
    endcase
    // Reset kills enables combinationally so an aborted store drops memwrite without a clock.
    if (!reset_n) begin
      bus.memwrite = 1'b0;
      bus.irwrite  = 1'b0;
      bus.regwrite = 1'b0;
      bus.pcwrite  = 1'b0;
      bus.branch   = 1'b0;
      bus.illegal  = 1'b0;
    end
  end

  assign bus.state = state_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed table-driven bench for mc_ctrl_fsm, plus a hand sequence for reset during MEMWR.
module tb_mc_ctrl_fsm;

  logic clk;
  logic reset_n;
  mc_ctrl_fsm_if bus ();

  mc_ctrl_fsm dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected vector: {state, we{memwrite,irwrite,regwrite,pcwrite,branch},
  // sel{iord,alusrca,regdst,memtoreg,immzext}, alusrcb, pcsrc, aluop, illegal}
  typedef struct {
    logic       rst_n;
    logic [5:0] op;
    logic       mr;
    logic [20:0] exp;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int errors = 0;

  function automatic vec_t v(logic rst_n, logic [5:0] op, logic mr, logic [3:0] st,
                             logic [4:0] we, logic [4:0] sel, logic [1:0] srcb,
                             logic [1:0] pcs, logic [1:0] aop, logic ill);
    vec_t r;
    r.rst_n = rst_n;
    r.op    = op;
    r.mr    = mr;
    r.exp   = {st, we, sel, srcb, pcs, aop, ill};
    return r;
  endfunction

  function automatic logic [20:0] observed();
    return {bus.state, bus.memwrite, bus.irwrite, bus.regwrite, bus.pcwrite, bus.branch,
            bus.iord, bus.alusrca, bus.regdst, bus.memtoreg, bus.immzext,
            bus.alusrcb, bus.pcsrc, bus.aluop, bus.illegal};
  endfunction

  task automatic check(input string name, input logic [20:0] exp);
    logic [20:0] got;
    got = observed();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b required %b", name, got, exp);
    end
  endtask

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, BEQ = 6'b000100;
  localparam logic [5:0] ADDI = 6'b001000, ORI = 6'b001101, JJ = 6'b000010, BAD = 6'b111111;

  initial begin
    reset_n       = 1'b0;
    bus.opcode    = 6'b0;
    bus.mem_ready = 1'b1;

    // Reset held: enables forced low even with mem_ready=1.
    vecs.push_back(v(0, LW,  1, 4'd0,  5'b00000, 5'b00000, 2'b01, 2'b00, 2'b00, 0));
    // lw: 0,1,2,3,4
    vecs.push_back(v(1, LW,  1, 4'd0,  5'b01010, 5'b00000, 2'b01, 2'b00, 2'b00, 0));
    vecs.push_back(v(1, LW,  1, 4'd1,  5'b00000, 5'b00000, 2'b11, 2'b00, 2'b00, 0));
    vecs.push_back(v(1, LW,  1, 4'd2,  5'b00000, 5'b01000, 2'b10, 2'b00, 2'b00, 0));
    vecs.push_back(v(1, LW,  1, 4'd3,  5'b00000, 5'b10000, 2'b00, 2'b00, 2'b00, 0));
    vecs.push_back(v(1, LW,  1, 4'd4,  5'b00100, 5'b00010, 2'b00, 2'b00, 2'b00, 0));
    // sw with two stall cycles in MEMWR
    vecs.push_back(v(1, SW,  1, 4'd0,  5'b01010, 5'b00000, 2'b01, 2'b00, 2'b00, 0));
    vecs.push_back(v(1, SW,  1, 4'd1,  5'b00000, 5'b00000, 2'b11, 2'b00, 2'b00, 0));
    vecs.push_back(v(1, SW,  1, 4'd2,  5'b00000, 5'b01000, 2'b10, 2'b00, 2'b00, 0));
    vecs.push_back(v(1, SW,  0, 4'd5,  5'b10000, 5'b10000, 2'b00, 2'b00, 2'b00, 0));
    vecs.push_back(v(1, SW,  0, 4'd5,  5'b10000, 5'b10000, 2'b00, 2'b00, 2'b00, 0));
    vecs.push_back(v(1, SW,  1, 4'd5,  5'b10000, 5'b10000, 2'b00, 2'b00, 2'b00, 0));
    // R-type then ori
    vecs.push_back(v(1, RT,  1, 4'd0,  5'b01010, 5'b00000, 2'b01, 2'b00, 2'b00, 0));
    vecs.push_back(v(1, RT,  1, 4'd1,  5'b00000, 5'b00000, 2'b11, 2'b00, 2'b00, 0));
    vecs.push_back(v(1, RT,  1, 4'd6,  5'b00000, 5'b01000, 2'b00, 2'b00, 2'b10, 0));
    vecs.push_back(v(1, RT,  1, 4'd7,  5'b00100, 5'b00100, 2'b00, 2'b00, 2'b00, 0));
    vecs.push_back(v(1, ORI, 1, 4'd0,  5'b01010, 5'b00000, 2'b01, 2'b00, 2'b00, 0));
    vecs.push_back(v(1, ORI, 1, 4'd1,  5'b00000, 5'b00000, 2'b11, 2'b00, 2'b00, 0));
    vecs.push_back(v(1, ORI, 1, 4'd11, 5'b00000, 5'b01001, 2'b10, 2'b00, 2'b11, 0));
    vecs.push_back(v(1, ORI, 1, 4'd12, 5'b00100, 5'b00000, 2'b00, 2'b00, 2'b00, 0));
    // beq then j, 3 cycles each
    vecs.push_back(v(1, BEQ, 1, 4'd0,  5'b01010, 5'b00000, 2'b01, 2'b00, 2'b00, 0));
    vecs.push_back(v(1, BEQ, 1, 4'd1,  5'b00000, 5'b00000, 2'b11, 2'b00, 2'b00, 0));
    vecs.push_back(v(1, BEQ, 1, 4'd8,  5'b00001, 5'b01000, 2'b00, 2'b01, 2'b01, 0));
    vecs.push_back(v(1, JJ,  1, 4'd0,  5'b01010, 5'b00000, 2'b01, 2'b00, 2'b00, 0));
    vecs.push_back(v(1, JJ,  1, 4'd1,  5'b00000, 5'b00000, 2'b11, 2'b00, 2'b00, 0));
    vecs.push_back(v(1, JJ,  1, 4'd13, 5'b00010, 5'b00000, 2'b00, 2'b10, 2'b00, 0));
    // illegal opcode: one-cycle pulse, then FETCH stalled 3 cycles
    vecs.push_back(v(1, BAD, 1, 4'd0,  5'b01010, 5'b00000, 2'b01, 2'b00, 2'b00, 0));
    vecs.push_back(v(1, BAD, 1, 4'd1,  5'b00000, 5'b00000, 2'b11, 2'b00, 2'b00, 1));
    vecs.push_back(v(1, BAD, 0, 4'd0,  5'b00000, 5'b00000, 2'b01, 2'b00, 2'b00, 0));
    vecs.push_back(v(1, BAD, 0, 4'd0,  5'b00000, 5'b00000, 2'b01, 2'b00, 2'b00, 0));
    vecs.push_back(v(1, BAD, 0, 4'd0,  5'b00000, 5'b00000, 2'b01, 2'b00, 2'b00, 0));
    // addi
    vecs.push_back(v(1, ADDI, 1, 4'd0,  5'b01010, 5'b00000, 2'b01, 2'b00, 2'b00, 0));
    vecs.push_back(v(1, ADDI, 1, 4'd1,  5'b00000, 5'b00000, 2'b11, 2'b00, 2'b00, 0));
    vecs.push_back(v(1, ADDI, 1, 4'd9,  5'b00000, 5'b01000, 2'b10, 2'b00, 2'b00, 0));
    vecs.push_back(v(1, ADDI, 1, 4'd10, 5'b00100, 5'b00000, 2'b00, 2'b00, 2'b00, 0));
    // sw parked in MEMWR for the reset sequence below
    vecs.push_back(v(1, SW,  1, 4'd0,  5'b01010, 5'b00000, 2'b01, 2'b00, 2'b00, 0));
    vecs.push_back(v(1, SW,  1, 4'd1,  5'b00000, 5'b00000, 2'b11, 2'b00, 2'b00, 0));
    vecs.push_back(v(1, SW,  1, 4'd2,  5'b00000, 5'b01000, 2'b10, 2'b00, 2'b00, 0));
    vecs.push_back(v(1, SW,  0, 4'd5,  5'b10000, 5'b10000, 2'b00, 2'b00, 2'b00, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      reset_n       = vecs[i].rst_n;
      bus.opcode    = vecs[i].op;
      bus.mem_ready = vecs[i].mr;
      #1;
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Still stalled in MEMWR, then reset asserted mid-cycle.
    @(negedge clk);
    #1;
    check("memwr_stall", {4'd5, 5'b10000, 5'b10000, 2'b00, 2'b00, 2'b00, 1'b0});
    reset_n = 1'b0;
    #1;
    check("async_abort", {4'd0, 5'b00000, 5'b00000, 2'b01, 2'b00, 2'b00, 1'b0});

    // Release and resume with lw.
    @(negedge clk);
    reset_n       = 1'b1;
    bus.opcode    = LW;
    bus.mem_ready = 1'b1;
    #1;
    check("resume_fetch", {4'd0, 5'b01010, 5'b00000, 2'b01, 2'b00, 2'b00, 1'b0});
    @(negedge clk);
    #1;
    check("resume_decode", {4'd1, 5'b00000, 5'b00000, 2'b11, 2'b00, 2'b00, 1'b0});
    @(negedge clk);
    #1;
    check("resume_memadr", {4'd2, 5'b00000, 5'b01000, 2'b10, 2'b00, 2'b00, 1'b0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
